gate_tester: RTL and testbench
==============================

GATE_TESTER -- requirements
Module: gate_tester

Interface
REQ-001 The module SHALL have parameter TRUTH, default 4'b1000, giving the expected gate output for input index {a,b}: bit 0 for 00 through bit 3 for 11 (the default is 2-input AND).
REQ-002 The module SHALL have parameter SETTLE, default 2, legal range 1..15, giving the number of cycles each vector is held before it is sampled.
REQ-003 The module SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-004 The module SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The module SHALL have port start, input, 1 bit: request a test run; sampled in IDLE only.
REQ-006 The module SHALL have port a_out, output, 1 bit: stimulus A to the gate under test.
REQ-007 The module SHALL have port b_out, output, 1 bit: stimulus B to the gate under test.
REQ-008 The module SHALL have port f_in, input, 1 bit: response F from the gate under test.
REQ-009 The module SHALL have port busy, output, 1 bit: high in the DRIVE and SAMPLE states.
REQ-010 The module SHALL have port done, output, 1 bit: one-cycle pulse when a run ends.
REQ-011 The module SHALL have port pass, output, 1 bit: high when the last completed run had zero mismatches.
REQ-012 The module SHALL have port err_count, output, 3 bits: number of mismatches in the current or last run (0..4).
REQ-013 The module SHALL have port fail_vec, output, 4 bits: bit i set when vector index i mismatched.

Function
REQ-014 The module SHALL implement FSM states IDLE, DRIVE, SAMPLE and DONE, with IDLE as the reset state.
REQ-015 On IDLE with start=1 at a rising edge, the FSM SHALL go to DRIVE with vector index 0, and SHALL clear err_count, fail_vec and pass at that same edge.
REQ-016 Vectors SHALL be applied in order 00, 01, 10, 11 as {a_out,b_out}; a_out and b_out SHALL change only at the edge that enters DRIVE.
REQ-017 Each vector SHALL spend SETTLE cycles in DRIVE followed by 1 cycle in SAMPLE; f_in SHALL be compared with TRUTH[idx] at the edge leaving SAMPLE.
REQ-018 On a mismatch at that edge, the module SHALL increment err_count and set fail_vec[idx].
REQ-019 From SAMPLE, the FSM SHALL go to DRIVE with idx+1 when idx<3, and to DONE when idx=3; a full run is therefore 4*(SETTLE+1) busy cycles.
REQ-020 DONE SHALL last exactly 1 cycle, with done=1 and pass=(err_count==0); the FSM SHALL then return to IDLE.
REQ-021 The module SHALL hold pass, err_count and fail_vec after DONE until the next accepted start.
REQ-022 The module SHALL ignore start while busy=1 or in DONE, with no restart and no queuing.
REQ-023 In IDLE and DONE, a_out and b_out SHALL be 0.
REQ-024 A start held continuously high SHALL launch a new run on the first IDLE cycle after DONE.
REQ-025 The module SHALL have no combinational path from f_in or start to any output.

Reset
REQ-026 On rst_n=0, the module SHALL immediately go to IDLE and drive a_out=0, b_out=0, busy=0, done=0, pass=0, err_count=0, fail_vec=0, independent of clk.
REQ-027 Reset asserted mid-run SHALL discard that run; after rst_n rises, the module SHALL wait in IDLE for a new start.

Configuration
REQ-028 When macro GATE_TESTER_STOP_ON_FAIL_EN is defined, the FSM SHALL go from SAMPLE directly to DONE on the first mismatch, with the remaining vectors not applied.
REQ-029 When GATE_TESTER_STOP_ON_FAIL_EN is undefined, all four vectors SHALL always be applied, as in REQ-019.

Verification
REQ-030 The bench SHALL cover: correct AND gate, SETTLE=2, start pulse -> busy for 12 cycles, done pulse, pass=1, err_count=0, fail_vec=4'b0000.
REQ-031 The bench SHALL cover: f_in tied to 1, default TRUTH -> err_count=3, fail_vec=4'b0111, pass=0.
REQ-032 The bench SHALL cover: TRUTH=4'b1110 (OR) against an AND gate -> err_count=2, fail_vec=4'b0110, pass=0.
REQ-033 The bench SHALL cover: start pulsed during vector 2, then rst_n=0 during vector 3 -> no restart; all outputs go to 0 asynchronously; the next start runs a full sequence.
REQ-034 The bench SHALL cover: GATE_TESTER_STOP_ON_FAIL_EN defined, f_in tied to 1 -> done after 3 busy cycles (SETTLE=2), err_count=1, fail_vec=4'b0001.
REQ-035 The bench SHALL cover: start held high for 30 cycles with SETTLE=1 -> back-to-back runs, each with done spaced 10 cycles apart.

Source files
------------

// File: rtl/gate_tester.sv
// Exhaustive 2-input gate tester: drives the four {a,b} vectors, samples F after
// SETTLE cycles and reports mismatches. Optional macro: GATE_TESTER_STOP_ON_FAIL_EN.
module gate_tester #(
  parameter logic [3:0]  TRUTH  = 4'b1000,
  parameter int unsigned SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       a_out,
  output logic       b_out,
  input  logic       f_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] fail_vec
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned IDX_W = 2;
  localparam int unsigned ERR_W = 3;
  localparam int unsigned VEC_N = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               a_q, a_d;
  logic               b_q, b_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic [VEC_N-1:0]   fail_q, fail_d;
  logic               mismatch_c;
  logic               stop_c;

  assign mismatch_c = (f_in != TRUTH[idx_q]);

`ifdef GATE_TESTER_STOP_ON_FAIL_EN
  assign stop_c = mismatch_c;
`else
  assign stop_c = 1'b0;
`endif

  // State register and all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      fail_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    pass_d  = pass_q;
    err_d   = err_q;
    fail_d  = fail_q;

    case (state_q)
      IDLE: begin
        a_d = 1'b0;
        b_d = 1'b0;
        if (start) begin
          state_d = DRIVE;
          idx_d   = '0;
          cnt_d   = '0;
          err_d   = '0;
          fail_d  = '0;
          pass_d  = 1'b0;
        end
      end
      DRIVE: begin
        if (cnt_q == CNT_W'(SETTLE - 1)) begin
          state_d = SAMPLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SAMPLE: begin
        if (mismatch_c) begin
          err_d         = err_q + ERR_W'(1);
          fail_d[idx_q] = 1'b1;
        end
        if ((idx_q == IDX_W'(VEC_N - 1)) || stop_c) begin
          state_d = DONE;
          a_d     = 1'b0;
          b_d     = 1'b0;
          pass_d  = (err_d == '0);
        end else begin
          state_d    = DRIVE;
          idx_d      = idx_q + IDX_W'(1);
          cnt_d      = '0;
          {a_d, b_d} = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        a_d     = 1'b0;
        b_d     = 1'b0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == DRIVE) || (state_d == SAMPLE);
    done_d = (state_d == DONE);
  end

  assign a_out     = a_q;
  assign b_out     = b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_vec  = fail_q;

endmodule

// File: tb/tb_gate_tester.sv
// Directed bench for gate_tester: AND pass, stuck-at-1 F, OR-vs-AND, mid-run
// reset, and held-start back-to-back runs.
module tb_gate_tester;

  logic clk;
  logic rst_n;

  // Instance A: default TRUTH (AND), SETTLE=2
  logic       start_a, tie1_a, f_a, a_a, b_a, busy_a, done_a, pass_a;
  logic [2:0] err_a;
  logic [3:0] fv_a;
  // Instance O: TRUTH=OR, SETTLE=2, tested against an AND gate
  logic       start_o, f_o, a_o, b_o, busy_o, done_o, pass_o;
  logic [2:0] err_o;
  logic [3:0] fv_o;
  // Instance S: AND, SETTLE=1
  logic       start_s, f_s, a_s, b_s, busy_s, done_s, pass_s;
  logic [2:0] err_s;
  logic [3:0] fv_s;

  int checks = 0;
  int errors = 0;

  assign f_a = tie1_a ? 1'b1 : (a_a & b_a);
  assign f_o = a_o & b_o;
  assign f_s = a_s & b_s;

  gate_tester #(.TRUTH(4'b1000), .SETTLE(2)) u_and (
    .clk(clk), .rst_n(rst_n), .start(start_a), .a_out(a_a), .b_out(b_a),
    .f_in(f_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .err_count(err_a), .fail_vec(fv_a));

  gate_tester #(.TRUTH(4'b1110), .SETTLE(2)) u_or (
    .clk(clk), .rst_n(rst_n), .start(start_o), .a_out(a_o), .b_out(b_o),
    .f_in(f_o), .busy(busy_o), .done(done_o), .pass(pass_o),
    .err_count(err_o), .fail_vec(fv_o));

  gate_tester #(.TRUTH(4'b1000), .SETTLE(1)) u_s1 (
    .clk(clk), .rst_n(rst_n), .start(start_s), .a_out(a_s), .b_out(b_s),
    .f_in(f_s), .busy(busy_s), .done(done_s), .pass(pass_s),
    .err_count(err_s), .fail_vec(fv_s));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One start pulse on instance A, then count busy cycles until done
  task automatic run_a(output int busy_cnt, output bit got_done, output logic [23:0] seq);
    busy_cnt = 0;
    got_done = 0;
    seq      = '0;
    @(negedge clk) start_a = 1'b1;
    @(negedge clk) start_a = 1'b0;
    for (int i = 0; i < 60 && !got_done; i++) begin
      if (busy_a) begin
        if (busy_cnt < 12) seq = {seq[21:0], a_a, b_a};
        busy_cnt++;
      end
      if (done_a) got_done = 1;
      else @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({a_a, b_a, busy_a, done_a, pass_a, err_a, fv_a} !== 12'd0) begin
      errors++;
      $display("FAIL reset_a: got %b expected 0", {a_a, b_a, busy_a, done_a, pass_a, err_a, fv_a});
    end
    checks++;
    if ({a_o, b_o, busy_o, done_o, pass_o, err_o, fv_o, a_s, b_s, busy_s, done_s, pass_s, err_s, fv_s} !== 24'd0) begin
      errors++;
      $display("FAIL reset_os: got %b expected 0",
               {a_o, b_o, busy_o, done_o, pass_o, err_o, fv_o, a_s, b_s, busy_s, done_s, pass_s, err_s, fv_s});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_and_pass();
    int bc; bit gd; logic [23:0] seq;
    tie1_a = 1'b0;
    run_a(bc, gd, seq);
    checks++;
    if (!gd || bc != 12) begin
      errors++; $display("FAIL and_busy: got done=%0d busy=%0d expected done=1 busy=12", gd, bc);
    end
    checks++;
    if (seq !== 24'b00_00_00_01_01_01_10_10_10_11_11_11) begin
      errors++; $display("FAIL and_vectors: got %b expected 000000010101101010111111", seq);
    end
    checks++;
    if ({pass_a, err_a, fv_a, a_a, b_a, busy_a} !== {1'b1, 3'd0, 4'b0000, 3'b000}) begin
      errors++; $display("FAIL and_result: pass=%b err=%0d fv=%b a=%b b=%b busy=%b expected 1 0 0000 0 0 0",
                         pass_a, err_a, fv_a, a_a, b_a, busy_a);
    end
    repeat (3) @(negedge clk);
    checks++;
    if ({done_a, busy_a, pass_a, err_a, fv_a} !== {1'b0, 1'b0, 1'b1, 3'd0, 4'b0000}) begin
      errors++; $display("FAIL and_hold: done=%b busy=%b pass=%b err=%0d fv=%b expected 0 0 1 0 0000",
                         done_a, busy_a, pass_a, err_a, fv_a);
    end
  endtask

  task automatic test_stuck1();
    int bc; bit gd; logic [23:0] seq;
    tie1_a = 1'b1;
    run_a(bc, gd, seq);
`ifdef GATE_TESTER_STOP_ON_FAIL_EN
    checks++;
    if (!gd || bc != 3) begin
      errors++; $display("FAIL stuck1_busy: got done=%0d busy=%0d expected done=1 busy=3", gd, bc);
    end
    checks++;
    if ({pass_a, err_a, fv_a} !== {1'b0, 3'd1, 4'b0001}) begin
      errors++; $display("FAIL stuck1_result: pass=%b err=%0d fv=%b expected 0 1 0001", pass_a, err_a, fv_a);
    end
`else
    checks++;
    if (!gd || bc != 12) begin
      errors++; $display("FAIL stuck1_busy: got done=%0d busy=%0d expected done=1 busy=12", gd, bc);
    end
    checks++;
    if ({pass_a, err_a, fv_a} !== {1'b0, 3'd3, 4'b0111}) begin
      errors++; $display("FAIL stuck1_result: pass=%b err=%0d fv=%b expected 0 3 0111", pass_a, err_a, fv_a);
    end
`endif
    tie1_a = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_or_vs_and();
    int bc; bit gd;
    bc = 0; gd = 0;
    @(negedge clk) start_o = 1'b1;
    @(negedge clk) start_o = 1'b0;
    for (int i = 0; i < 60 && !gd; i++) begin
      if (busy_o) bc++;
      if (done_o) gd = 1;
      else @(negedge clk);
    end
`ifdef GATE_TESTER_STOP_ON_FAIL_EN
    checks++;
    if (!gd || bc != 6 || {pass_o, err_o, fv_o} !== {1'b0, 3'd1, 4'b0010}) begin
      errors++; $display("FAIL or_result: done=%0d busy=%0d pass=%b err=%0d fv=%b expected 1 6 0 1 0010",
                         gd, bc, pass_o, err_o, fv_o);
    end
`else
    checks++;
    if (!gd || bc != 12 || {pass_o, err_o, fv_o} !== {1'b0, 3'd2, 4'b0110}) begin
      errors++; $display("FAIL or_result: done=%0d busy=%0d pass=%b err=%0d fv=%b expected 1 12 0 2 0110",
                         gd, bc, pass_o, err_o, fv_o);
    end
`endif
    repeat (2) @(negedge clk);
  endtask

  task automatic test_abort_reset();
    int bc; bit gd; bit seen; logic [23:0] seq;
    tie1_a = 1'b0;
    seen = 0;
    @(negedge clk) start_a = 1'b1;
    @(negedge clk) start_a = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (busy_a && a_a && !b_a) seen = 1;
      else @(negedge clk);
    end
    start_a = 1'b1;
    @(negedge clk) start_a = 1'b0;
    checks++;
    if (!seen || {busy_a, a_a, b_a} !== 3'b110) begin
      errors++; $display("FAIL abort_no_restart: seen=%0d busy=%b a=%b b=%b expected 1 1 1 0", seen, busy_a, a_a, b_a);
    end
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (busy_a && a_a && b_a) seen = 1;
      else @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (!seen || {a_a, b_a, busy_a, done_a, pass_a, err_a, fv_a} !== 12'd0) begin
      errors++; $display("FAIL abort_async_reset: seen=%0d outs=%b expected 0", seen,
                         {a_a, b_a, busy_a, done_a, pass_a, err_a, fv_a});
    end
    @(negedge clk) rst_n = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if ({busy_a, done_a, a_a, b_a} !== 4'b0000) begin
      errors++; $display("FAIL abort_idle_wait: busy=%b done=%b a=%b b=%b expected 0000", busy_a, done_a, a_a, b_a);
    end
    run_a(bc, gd, seq);
    checks++;
    if (!gd || bc != 12 || {pass_a, err_a, fv_a} !== {1'b1, 3'd0, 4'b0000}) begin
      errors++; $display("FAIL abort_rerun: done=%0d busy=%0d pass=%b err=%0d fv=%b expected 1 12 1 0 0000",
                         gd, bc, pass_a, err_a, fv_a);
    end
  endtask

  task automatic test_back_to_back();
    int done_cyc[$];
    int cyc;
    cyc = 0;
    @(negedge clk) start_s = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      cyc++;
      if (done_s) begin
        done_cyc.push_back(cyc);
        checks++;
        if (pass_s !== 1'b1) begin
          errors++; $display("FAIL b2b_pass: cycle %0d pass=%b expected 1", cyc, pass_s);
        end
      end
    end
    start_s = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      cyc++;
      if (done_s) done_cyc.push_back(cyc);
    end
    checks++;
    if (done_cyc.size() != 3) begin
      errors++; $display("FAIL b2b_count: got %0d done pulses expected 3", done_cyc.size());
    end
    for (int k = 1; k < done_cyc.size(); k++) begin
      checks++;
      if (done_cyc[k] - done_cyc[k-1] != 10) begin
        errors++; $display("FAIL b2b_spacing: pulse %0d gap %0d expected 10", k, done_cyc[k] - done_cyc[k-1]);
      end
    end
    checks++;
    if (busy_s !== 1'b0) begin
      errors++; $display("FAIL b2b_idle: busy=%b expected 0", busy_s);
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    start_a = 1'b0;
    start_o = 1'b0;
    start_s = 1'b0;
    tie1_a  = 1'b0;
    test_reset();
    test_and_pass();
    test_stuck1();
    test_or_vs_and();
    test_abort_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
